// File: rtl/display_scan_mux_pkg.sv
// display_scan_mux_pkg: shared display source indices, digit width default and source packing helper
package display_scan_mux_pkg;
    localparam int SRC_CURRENT = 0;
    localparam int SRC_ALARM   = 1;
    localparam int SRC_KEYPAD  = 2;
    localparam int DIGIT_W_DEF = 4;
    function automatic int src_offset(input int src, input int digit, input int num_digits, input int digit_w);
        return (src * num_digits + digit) * digit_w;
    endfunction
endpackage

// File: rtl/display_scan_mux_scan_prescaler.sv
// scan_prescaler: counts 0..DIV-1 while enabled and flags the last count
module scan_prescaler #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int CNT_W = DIV > 1 ? $clog2(DIV) : 1;
    logic [CNT_W-1:0] cnt;
    always_comb tick = en && cnt == CNT_W'(DIV - 1);
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/display_scan_mux.sv
// display_scan_mux: frame-synchronous source select, blinking and leading-zero blanking for a scanned display
module display_scan_mux
    import display_scan_mux_pkg::*;
#(
    parameter int NUM_SOURCES = 3,
    parameter int NUM_DIGITS  = 4,
    parameter int DIGIT_W     = DIGIT_W_DEF,
    parameter int SCAN_DIV    = 1000,
    parameter int BLINK_DIV   = 64,
    localparam int SEL_W = NUM_SOURCES > 1 ? $clog2(NUM_SOURCES) : 1,
    localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_SOURCES*NUM_DIGITS*DIGIT_W-1:0] source_data,
    input  logic [SEL_W-1:0]                      selector,
    input  logic [NUM_DIGITS-1:0]                 blink_mask,
    input  logic                                  blank_leading,
    output logic [DIGIT_W-1:0]                    digit_value,
    output logic [NUM_DIGITS-1:0]                 digit_enable,
    output logic [IDX_W-1:0]                      digit_index,
    output logic                                  frame_start
);
    localparam int FC_W = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    logic                            run, tick, fs, lz, zero_hi;
    logic [IDX_W-1:0]                idx_n;
    logic [NUM_DIGITS*DIGIT_W-1:0]   snap, snap_n;
    logic [NUM_DIGITS-1:0]           mask, mask_n, en_n;
    logic                            blank, blank_n, blink_on, blink_n;
    logic [FC_W-1:0]                 fcnt, fcnt_n;
    logic [SEL_W-1:0]                src;
    logic [DIGIT_W-1:0]              val_n;
    scan_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
        .clk(clk),
        .reset(reset),
        .en(run),
        .tick(tick)
    );
    // run is low only on the first edge after reset, which is frame start 0
    always_comb begin
        fs = !run || (tick && digit_index == IDX_W'(NUM_DIGITS - 1));
        src = int'(selector) < NUM_SOURCES ? selector : '0;
        snap_n = snap;
        mask_n = mask;
        blank_n = blank;
        fcnt_n = fcnt;
        blink_n = blink_on;
        idx_n = tick ? digit_index + 1'b1 : digit_index;
        if (fs) begin
            idx_n = '0;
            mask_n = blink_mask;
            blank_n = blank_leading;
            for (int d = 0; d < NUM_DIGITS; d++)
                snap_n[d*DIGIT_W +: DIGIT_W] = source_data[src_offset(int'(src), d, NUM_DIGITS, DIGIT_W) +: DIGIT_W];
            if (run) begin
                fcnt_n = fcnt == FC_W'(BLINK_DIV - 1) ? '0 : fcnt + 1'b1;
                blink_n = fcnt == FC_W'(BLINK_DIV - 1) ? !blink_on : blink_on;
            end
        end
        val_n = snap_n[int'(idx_n)*DIGIT_W +: DIGIT_W];
        lz = 1'b0;
        zero_hi = 1'b1;
        for (int d = NUM_DIGITS - 1; d > 0; d--) begin
            zero_hi = zero_hi && snap_n[d*DIGIT_W +: DIGIT_W] == '0;
            if (IDX_W'(d) == idx_n) lz = zero_hi;
        end
        en_n = (mask_n[idx_n] && !blink_n) || (blank_n && lz) ? '0 : NUM_DIGITS'(1) << idx_n;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            run <= 1'b0;
            digit_index <= '0;
            snap <= '0;
            mask <= '0;
            blank <= 1'b0;
            fcnt <= '0;
            blink_on <= 1'b1;
            digit_value <= '0;
            digit_enable <= '0;
            frame_start <= 1'b0;
        end else begin
            run <= 1'b1;
            digit_index <= idx_n;
            snap <= snap_n;
            mask <= mask_n;
            blank <= blank_n;
            fcnt <= fcnt_n;
            blink_on <= blink_n;
            digit_value <= val_n;
            digit_enable <= en_n;
            frame_start <= fs;
        end
endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: directed and random scan checks against a frame-arithmetic reference model
module tb_display_scan_mux;
    localparam int NS = 3, ND = 4, DW = 4, SD = 4, BD = 2, FRAME = ND * SD;
    logic clk = 1'b0, reset = 1'b1;
    logic [NS*ND*DW-1:0] source_data = '0;
    logic [1:0] selector = '0;
    logic [ND-1:0] blink_mask = '0;
    logic blank_leading = 1'b0;
    logic [DW-1:0] digit_value;
    logic [ND-1:0] digit_enable;
    logic [1:0] digit_index;
    logic frame_start;
    int tests = 0, errors = 0;
    bit m_run = 0, m_blank = 0, rand_on = 0;
    int e = 0;
    int m_snap[ND];
    logic [ND-1:0] m_mask = '0;
    int x_val = 0, x_en = 0, x_idx = 0, x_fs = 0;
    always #5 clk = ~clk;
    display_scan_mux #(.NUM_SOURCES(NS), .NUM_DIGITS(ND), .DIGIT_W(DW), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk(clk),
        .reset(reset),
        .source_data(source_data),
        .selector(selector),
        .blink_mask(blink_mask),
        .blank_leading(blank_leading),
        .digit_value(digit_value),
        .digit_enable(digit_enable),
        .digit_index(digit_index),
        .frame_start(frame_start)
    );
    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask
    task automatic check_all();
        check("digit_value", int'(digit_value), x_val);
        check("digit_enable", int'(digit_enable), x_en);
        check("digit_index", int'(digit_index), x_idx);
        check("frame_start", int'(frame_start), x_fs);
    endtask
    task automatic model_reset();
        m_run = 0;
        x_val = 0; x_en = 0; x_idx = 0; x_fs = 0;
    endtask
    // Position within the frame and blink phase follow directly from the edge count since reset release
    task automatic model_edge();
        int pos, k, d, s;
        bit blink, lz;
        if (!m_run) begin e = 0; m_run = 1; end else e++;
        pos = e % FRAME;
        k = e / FRAME;
        d = pos / SD;
        if (pos == 0) begin
            s = int'(selector) < NS ? int'(selector) : 0;
            for (int i = 0; i < ND; i++) m_snap[i] = int'(source_data[(s*ND+i)*DW +: DW]);
            m_mask = blink_mask;
            m_blank = blank_leading;
        end
        blink = ((k / BD) % 2) == 0;
        lz = 0;
        if (m_blank && d != 0) begin
            lz = 1;
            for (int j = d; j < ND; j++) if (m_snap[j] != 0) lz = 0;
        end
        x_fs = pos == 0 ? 1 : 0;
        x_idx = d;
        x_val = m_snap[d];
        x_en = ((m_mask[d] && !blink) || lz) ? 0 : (1 << d);
    endtask
    task automatic set_src(input int s, input logic [15:0] v);
        source_data[s*ND*DW +: 16] = v;
    endtask
    task automatic randomize_inputs();
        int s, nz;
        if ($urandom_range(0, 7) == 0) selector = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 11) == 0) begin
            s = $urandom_range(0, NS - 1);
            nz = $urandom_range(0, ND);
            for (int i = 0; i < ND; i++)
                source_data[(s*ND+i)*DW +: DW] = i >= ND - nz ? 4'd0 : 4'($urandom_range(0, 9));
        end
        if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
        if ($urandom_range(0, 15) == 0) blank_leading = ~blank_leading;
        reset = $urandom_range(0, 399) == 0;
    endtask
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            if (reset) model_reset(); else model_edge();
            @(negedge clk);
            check_all();
            if (rand_on) randomize_inputs();
        end
    endtask
    initial begin
        for (int i = 0; i < ND; i++) m_snap[i] = 0;
        #1 check_all();
        cycles(2);
        set_src(0, 16'h1234);
        reset = 1'b0;
        cycles(2 * FRAME);
        set_src(1, 16'h0630);
        cycles(6);
        selector = 2'd1;
        cycles(2 * FRAME - 6);
        selector = 2'd3;
        cycles(2 * FRAME);
        selector = 2'd0;
        blink_mask = 4'b1100;
        cycles(6 * FRAME);
        blink_mask = 4'b0000;
        set_src(0, 16'h0005);
        blank_leading = 1'b1;
        cycles(2 * FRAME);
        set_src(0, 16'h0000);
        cycles(2 * FRAME);
        set_src(0, 16'h1234);
        blank_leading = 1'b0;
        for (int i = 0; i < 2 * FRAME && x_idx != 2; i++) cycles(1);
        cycles(1);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        cycles(2);
        reset = 1'b0;
        cycles(2 * FRAME);
        rand_on = 1;
        cycles(3000);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
